// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester and memory handshake signals
// master = arbiter side, slave = requesters plus memory side
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              ifu_req_valid;
    logic              ifu_req_ready;
    logic [ADDR_W-1:0] ifu_addr;
    logic              ifu_resp_valid;
    logic [DATA_W-1:0] ifu_rdata;

    logic                lsu_req_valid;
    logic                lsu_req_ready;
    logic [ADDR_W-1:0]   lsu_addr;
    logic                lsu_wen;
    logic [DATA_W-1:0]   lsu_wdata;
    logic [DATA_W/8-1:0] lsu_wmask;
    logic                lsu_resp_valid;
    logic [DATA_W-1:0]   lsu_rdata;

    logic                mem_req_valid;
    logic                mem_req_ready;
    logic [ADDR_W-1:0]   mem_addr;
    logic                mem_wen;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W/8-1:0] mem_wmask;
    logic                mem_resp_valid;
    logic [DATA_W-1:0]   mem_rdata;

    modport master (
        input  ifu_req_valid, ifu_addr,
        output ifu_req_ready, ifu_resp_valid, ifu_rdata,
        input  lsu_req_valid, lsu_addr, lsu_wen,
        input  lsu_wdata, lsu_wmask,
        output lsu_req_ready, lsu_resp_valid, lsu_rdata,
        output mem_req_valid, mem_addr, mem_wen,
        output mem_wdata, mem_wmask,
        input  mem_req_ready, mem_resp_valid, mem_rdata
    );

    modport slave (
        output ifu_req_valid, ifu_addr,
        input  ifu_req_ready, ifu_resp_valid, ifu_rdata,
        output lsu_req_valid, lsu_addr, lsu_wen,
        output lsu_wdata, lsu_wmask,
        input  lsu_req_ready, lsu_resp_valid, lsu_rdata,
        input  mem_req_valid, mem_addr, mem_wen,
        input  mem_wdata, mem_wmask,
        output mem_req_ready, mem_resp_valid, mem_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: IFU/LSU share one memory port, one txn in flight
// Optional watchdog: define MEM_ARB_TIMEOUT_EN (adds timeout_err)
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
`ifdef MEM_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 255
`endif
) (
    input  logic clk,
    input  logic reset,
    mem_port_arbiter_if.master bus,
`ifdef MEM_ARB_TIMEOUT_EN
    output logic timeout_err,
`endif
    output logic busy
);
    localparam int MW = DATA_W / 8;
    localparam int SC_W =
        (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [SC_W-1:0] SL = SC_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_t;

    state_t            state_q, state_d;
    logic [SC_W-1:0]   starve_q, starve_d;
    logic              own_q, own_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wen_q, wen_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [MW-1:0]     wmask_q, wmask_d;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TMO = TO_W'(TIMEOUT_CYCLES);
    logic [TO_W-1:0] wdog_q, wdog_d;
    logic            terr_q, terr_d;
    assign timeout_err = terr_q;
`endif

    logic ifu_win;
    logic lsu_win;
    logic starved;

    // IFU wins only when alone or when the LSU has starved it
    assign starved = (STARVE_LIMIT != 0) && (starve_q == SL);
    assign ifu_win = reset && bus.ifu_req_valid &&
                     (!bus.lsu_req_valid || starved);
    assign lsu_win = reset && bus.lsu_req_valid && !ifu_win;

    assign busy      = (state_q != IDLE);
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wen   = wen_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_wmask = wmask_q;

    // state and latched request register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            starve_q <= '0;
            own_q    <= 1'b0;
            addr_q   <= '0;
            wen_q    <= 1'b0;
            wdata_q  <= '0;
            wmask_q  <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
            wdog_q   <= '0;
            terr_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            own_q    <= own_d;
            addr_q   <= addr_d;
            wen_q    <= wen_d;
            wdata_q  <= wdata_d;
            wmask_q  <= wmask_d;
`ifdef MEM_ARB_TIMEOUT_EN
            wdog_q   <= wdog_d;
            terr_q   <= terr_d;
`endif
        end
    end

    // arbitration, next state and handshake outputs
    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        own_d    = own_q;
        addr_d   = addr_q;
        wen_d    = wen_q;
        wdata_d  = wdata_q;
        wmask_d  = wmask_q;
        bus.ifu_req_ready  = 1'b0;
        bus.lsu_req_ready  = 1'b0;
        bus.ifu_resp_valid = 1'b0;
        bus.lsu_resp_valid = 1'b0;
        bus.ifu_rdata      = '0;
        bus.lsu_rdata      = '0;
        bus.mem_req_valid  = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
        wdog_d = wdog_q;
        terr_d = terr_q;
`endif
        unique case (state_q)
            IDLE: begin
                unique case (1'b1)
                    ifu_win: begin
                        bus.ifu_req_ready = 1'b1;
                        starve_d = '0;
                        own_d    = 1'b0;
                        addr_d   = bus.ifu_addr;
                        wen_d    = 1'b0;
                        wdata_d  = '0;
                        wmask_d  = '0;
                        state_d  = ISSUE;
                    end
                    lsu_win: begin
                        bus.lsu_req_ready = 1'b1;
                        if (bus.ifu_req_valid && starve_q != SL)
                            starve_d = starve_q + 1'b1;
                        own_d   = 1'b1;
                        addr_d  = bus.lsu_addr;
                        wen_d   = bus.lsu_wen;
                        wdata_d = bus.lsu_wdata;
                        wmask_d = bus.lsu_wen ?
                                  bus.lsu_wmask : '0;
                        state_d = ISSUE;
                    end
                    default: ;
                endcase
`ifdef MEM_ARB_TIMEOUT_EN
                if (state_d == ISSUE)
                    wdog_d = '0;
`endif
            end
            ISSUE: begin
                bus.mem_req_valid = 1'b1;
                if (bus.mem_req_ready)
                    state_d = WAIT;
            end
            WAIT: begin
                if (bus.mem_resp_valid) begin
                    if (own_q) begin
                        bus.lsu_resp_valid = 1'b1;
                        bus.lsu_rdata = wen_q ?
                                        '0 : bus.mem_rdata;
                    end else begin
                        bus.ifu_resp_valid = 1'b1;
                        bus.ifu_rdata = bus.mem_rdata;
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef MEM_ARB_TIMEOUT_EN
        // watchdog aborts the txn with a poisoned response
        if (state_q != IDLE) begin
            wdog_d = wdog_q + 1'b1;
            if (wdog_q == TMO) begin
                bus.mem_req_valid  = 1'b0;
                bus.ifu_resp_valid = !own_q;
                bus.lsu_resp_valid = own_q;
                bus.ifu_rdata = own_q ?
                    '0 : DATA_W'(32'hDEADBEEF);
                bus.lsu_rdata = own_q ?
                    DATA_W'(32'hDEADBEEF) : '0;
                terr_d  = 1'b1;
                state_d = IDLE;
            end
        end
`endif
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single physical memory port between the instruction-fetch requester (IFU) and the load/store requester (LSU).
- Uses valid/ready request handshakes and allows only one outstanding transaction at a time.
- Sits between the core front-end/execute stages and the memory model (DPI-backed pmem or bus bridge).
- LSU has fixed priority, with a starvation override so the IFU is guaranteed forward progress.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width of all ports.
- STARVE_LIMIT, 4, consecutive LSU grants that may occur while the IFU waits before the IFU is forced to win; 0 means pure LSU priority.
- TIMEOUT_CYCLES, 255, watchdog limit (only used with MEM_ARB_TIMEOUT_EN).

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset (asserted at 0)
- ifu_req_valid  in  1  IFU fetch request
- ifu_req_ready  out  1  IFU request accepted this cycle
- ifu_addr  in  ADDR_W  fetch address
- ifu_resp_valid  out  1  one-cycle pulse: fetch data valid
- ifu_rdata  out  DATA_W  fetch data
- lsu_req_valid  in  1  LSU request
- lsu_req_ready  out  1  LSU request accepted this cycle
- lsu_addr  in  ADDR_W  load/store address
- lsu_wen  in  1  1 = store, 0 = load
- lsu_wdata  in  DATA_W  store data
- lsu_wmask  in  DATA_W/8  byte write mask
- lsu_resp_valid  out  1  one-cycle pulse: load data valid / store acknowledged
- lsu_rdata  out  DATA_W  load data; 0 for stores
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory accepts request
- mem_addr  out  ADDR_W  latched address
- mem_wen  out  1  latched write enable
- mem_wdata  out  DATA_W  latched write data
- mem_wmask  out  DATA_W/8  latched mask; 0 for reads
- mem_resp_valid  in  1  memory response (read data or write ack)
- mem_rdata  in  DATA_W  memory read data
- busy  out  1  state != IDLE

Behaviour:
- FSM states: IDLE, ISSUE, WAIT.
- Reset (reset=0, asynchronous):
  - state=IDLE, starve_cnt=0, owner=IFU, all latched request fields 0.
  - All outputs 0: *_ready, *_resp_valid, mem_req_valid, busy.
- IDLE:
  - Ready signals are combinational: the granted requester sees ready=1 in the same cycle its valid=1; the other sees ready=0.
  - Arbitration when both are valid: LSU wins unless STARVE_LIMIT!=0 and starve_cnt==STARVE_LIMIT, in which case the IFU wins.
  - On a grant: latch addr/wen/wdata/wmask (IFU grant forces wen=0, wmask=0), set owner, go to ISSUE.
  - Nothing valid: stay in IDLE, both ready=0.
- starve_cnt:
  - Increments on an LSU grant while ifu_req_valid=1, saturating at STARVE_LIMIT.
  - Clears on any IFU grant.
  - Otherwise holds.
- ISSUE:
  - mem_req_valid=1 with the latched fields, held stable until mem_req_ready=1, then go to WAIT.
  - mem_resp_valid is ignored in ISSUE.
- WAIT:
  - mem_req_valid=0.
  - On mem_resp_valid=1: owner's resp_valid=1 for exactly that cycle, with rdata=mem_rdata passed through combinationally (lsu_rdata=0 if the latched wen=1). Go to IDLE.
  - The non-owner's resp_valid stays 0 at all times.
- mem_resp_valid outside WAIT: ignored, no output effect.
- Latency: grant at cycle T → mem_req_valid at T+1 → earliest response (mem_req_ready at T+1, mem_resp_valid at T+2) reaches the requester at T+2 → next grant possible at T+3.
- No request is accepted while busy=1; both ready=0 in ISSUE and WAIT.
- Reset asserted mid-transaction: the transaction is dropped silently with no response pulse. The memory side must tolerate an abandoned request.

Optional Feature:
- Macro: MEM_ARB_TIMEOUT_EN.
- When defined:
  - Adds output port timeout_err (1 bit, reset 0) and a watchdog counter that clears on entering ISSUE and counts every cycle in ISSUE or WAIT.
  - When the count reaches TIMEOUT_CYCLES: timeout_err is set sticky until reset, the owner's resp_valid pulses once with rdata=32'hDEADBEEF, mem_req_valid drops, and the FSM returns to IDLE.
- When undefined: no timeout_err port and no counter; the FSM waits indefinitely.

Test Plan:
- Single IFU fetch: ifu_req_valid=1 with addr 0x80000000, mem ready immediately, response 0x00100073 one cycle later → ifu_ready at T, mem_addr=0x80000000 at T+1, ifu_resp_valid with rdata 0x00100073 at T+2, busy low at T+3.
- Simultaneous requests: both valid, STARVE_LIMIT=4 → LSU granted first; IFU granted on the next IDLE cycle once the LSU drops valid.
- Starvation: LSU valid continuously, IFU valid continuously → exactly 4 LSU grants, then an IFU grant, then starve_cnt=0 and the LSU wins again.
- Store: lsu_wen=1, addr 0x80001004, wdata 0x12345678, wmask 0x3, mem_req_ready delayed 3 cycles → mem fields held stable for all 3 cycles; lsu_resp_valid pulse with lsu_rdata=0.
- Reset mid-WAIT: reset=0 while in WAIT → busy, mem_req_valid and resp_valid read 0 immediately (asynchronously); a later mem_resp_valid produces no pulse; the next request proceeds normally.
- With MEM_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, memory never responds → after 8 cycles, timeout_err=1, owner resp_valid pulse with 0xDEADBEEF, FSM back in IDLE.
